// File: rtl/sa_pkg.sv
// Shared types and defaults for the systolic-array controller.
package sa_pkg;

  typedef enum logic [1:0] {
    SA_IDLE    = 2'b00,
    SA_PRELOAD = 2'b01,
    SA_STREAM  = 2'b10,
    SA_FLUSH   = 2'b11
  } sa_state_e;

  localparam int SA_DIM_DEF = 4;

endpackage

// File: rtl/sa_controller.sv
// Sequences one matrix job on a SA_DIM x SA_DIM systolic array:
// weight preload, M-row input streaming, then a drain flush.
module sa_controller
  import sa_pkg::*;
#(
  parameter int SA_DIM = SA_DIM_DEF,
  parameter int MW     = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [MW-1:0] m_len_i,
  input  logic          abort_i,
  input  logic          w_valid_i,
  output logic          w_ready_o,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  output logic          preload_en_o,
  output logic          shift_en_o,
  output logic          flush_o,
  output logic [1:0]    state_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam int WCW       = (SA_DIM > 1) ? $clog2(SA_DIM) : 1;
  localparam int FLUSH_LEN = 2 * SA_DIM - 1;
  localparam int FCW       = $clog2(FLUSH_LEN + 1);

  sa_state_e      state, state_n;
  logic [WCW-1:0] w_cnt, w_cnt_n;
  logic [MW-1:0]  in_cnt, in_cnt_n;
  logic [FCW-1:0] flush_cnt, flush_cnt_n;
  logic [MW-1:0]  m_len, m_len_n;
  logic           done_q, done_n;
  logic           w_hs, in_hs;

  assign w_ready_o    = (state == SA_PRELOAD);
  assign in_ready_o   = (state == SA_STREAM);
  assign flush_o      = (state == SA_FLUSH);
  assign busy_o       = (state != SA_IDLE);
  assign state_o      = state;
  assign done_o       = done_q;
  assign w_hs         = w_valid_i && w_ready_o;
  assign in_hs        = in_valid_i && in_ready_o;
  assign preload_en_o = w_hs;
  assign shift_en_o   = in_hs || flush_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SA_IDLE;
      w_cnt     <= '0;
      in_cnt    <= '0;
      flush_cnt <= '0;
      m_len     <= '0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_n;
      w_cnt     <= w_cnt_n;
      in_cnt    <= in_cnt_n;
      flush_cnt <= flush_cnt_n;
      m_len     <= m_len_n;
      done_q    <= done_n;
    end
  end

  always_comb begin
    state_n     = state;
    w_cnt_n     = w_cnt;
    in_cnt_n    = in_cnt;
    flush_cnt_n = flush_cnt;
    m_len_n     = m_len;
    done_n      = 1'b0;
    case (state)
      SA_IDLE: begin
        if (start_i) begin
          if (m_len_i != '0) begin
            state_n = SA_PRELOAD;
            m_len_n = m_len_i;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      SA_PRELOAD: begin
        if (w_hs) begin
          if (w_cnt == WCW'(SA_DIM - 1)) begin
            state_n = SA_STREAM;
            w_cnt_n = '0;
          end else begin
            w_cnt_n = w_cnt + WCW'(1);
          end
        end
      end
      SA_STREAM: begin
        // m_len is never zero here, so m_len-1 cannot wrap; M=2^MW-1 tops in_cnt at 2^MW-2.
        if (in_hs) begin
          if (in_cnt == m_len - MW'(1)) begin
            state_n  = SA_FLUSH;
            in_cnt_n = '0;
          end else begin
            in_cnt_n = in_cnt + MW'(1);
          end
        end
      end
      SA_FLUSH: begin
        if (flush_cnt == FCW'(FLUSH_LEN - 1)) begin
          state_n     = SA_IDLE;
          flush_cnt_n = '0;
          done_n      = 1'b1;
        end else begin
          flush_cnt_n = flush_cnt + FCW'(1);
        end
      end
      default: state_n = SA_IDLE;
    endcase
    // Abort wins over any handshake or flush completion in the same cycle.
    if (abort_i && state != SA_IDLE) begin
      state_n     = SA_IDLE;
      w_cnt_n     = '0;
      in_cnt_n    = '0;
      flush_cnt_n = '0;
      done_n      = 1'b0;
    end
  end

endmodule

// File: tb/tb_sa_controller.sv
// Vector table, directed corner sequences and a randomized run against a phase-count model.
module tb_sa_controller;

  localparam int D  = 4;
  localparam int MW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i, abort_i, w_valid_i, in_valid_i;
  logic [MW-1:0] m_len_i;
  logic          w_ready_o, in_ready_o, preload_en_o, shift_en_o, flush_o, busy_o, done_o;
  logic [1:0]    state_o;

  always #5 clk = ~clk;

  sa_controller #(.SA_DIM(D), .MW(MW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .m_len_i(m_len_i), .abort_i(abort_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .preload_en_o(preload_en_o), .shift_en_o(shift_en_o),
    .flush_o(flush_o), .state_o(state_o), .busy_o(busy_o), .done_o(done_o)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       start;
    logic [7:0] m;
    logic       abort, wv, iv;
    logic [1:0] st;
    logic       wr, ir, pe, se, fl, dn;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [8:0] outs();
    return {state_o, busy_o, w_ready_o, in_ready_o, preload_en_o, shift_en_o, flush_o, done_o};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void add(input logic s, input logic [7:0] m, input logic a, input logic wv,
                              input logic iv, input logic [1:0] st, input logic wr, input logic ir,
                              input logic pe, input logic se, input logic fl, input logic dn);
    vec_t v;
    v.start = s; v.m = m; v.abort = a; v.wv = wv; v.iv = iv;
    v.st = st; v.wr = wr; v.ir = ir; v.pe = pe; v.se = se; v.fl = fl; v.dn = dn;
    tbl.push_back(v);
  endfunction

  task automatic drive(input logic s, input logic [7:0] m, input logic a, input logic wv, input logic iv);
    start_i = s; m_len_i = m; abort_i = a; w_valid_i = wv; in_valid_i = iv;
  endtask

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  // Reference model: remaining work per phase; the phase is whichever count is still pending.
  int w_left, r_left, f_left;
  bit done_m;

  function automatic logic [8:0] model_outs();
    logic [1:0] st;
    logic wr, ir;
    st = (w_left > 0) ? 2'd1 : (r_left > 0) ? 2'd2 : (f_left > 0) ? 2'd3 : 2'd0;
    wr = (st == 2'd1);
    ir = (st == 2'd2);
    return {st, st != 2'd0, wr, ir, w_valid_i & wr, (in_valid_i & ir) | (st == 2'd3), st == 2'd3, done_m};
  endfunction

  function automatic void model_step();
    logic [8:0] o;
    bit nd;
    o  = model_outs();
    nd = 1'b0;
    if (abort_i && o[8:7] != 2'd0) begin
      w_left = 0; r_left = 0; f_left = 0;
    end else if (o[8:7] == 2'd0) begin
      if (start_i) begin
        if (m_len_i != 0) begin
          w_left = D; r_left = int'(m_len_i); f_left = 2 * D - 1;
        end else nd = 1'b1;
      end
    end else if (o[8:7] == 2'd1) begin
      if (w_valid_i) w_left--;
    end else if (o[8:7] == 2'd2) begin
      if (in_valid_i) r_left--;
    end else begin
      f_left--;
      if (f_left == 0) nd = 1'b1;
    end
    done_m = nd;
  endfunction

  initial begin
    int cnt, hit;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    #12;
    chk("reset_outs", outs(), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Full M=3 job, zero-length start, start ignored during PRELOAD (plus one stall)
    add(1, 3, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 1, 1, 1, 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 1, 2, 0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 7; i++) add(0, 0, 0, 1, 1, 3, 0, 0, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 5, 0, 1, 0, 1, 1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 5, 0, 1, 0, 1, 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 2; i++) add(0, 0, 0, 0, 1, 2, 0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 7; i++) add(0, 0, 0, 0, 0, 3, 0, 0, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].start, tbl[i].m, tbl[i].abort, tbl[i].wv, tbl[i].iv);
      @(negedge clk);
      chk($sformatf("vec%0d", i), outs(),
          {tbl[i].st, tbl[i].st != 2'd0, tbl[i].wr, tbl[i].ir, tbl[i].pe, tbl[i].se, tbl[i].fl, tbl[i].dn});
      next_cyc();
    end

    // M=2 with a 5-cycle input gap mid-STREAM
    drive(1, 2, 0, 1, 0); next_cyc();
    drive(0, 0, 0, 1, 0);
    repeat (4) next_cyc();
    drive(0, 0, 0, 0, 1); @(negedge clk);
    chk("gap_first_shift", {state_o, shift_en_o}, {2'd2, 1'b1});
    next_cyc();
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("gap_hold%0d", i), {state_o, shift_en_o}, {2'd2, 1'b0});
      next_cyc();
    end
    drive(0, 0, 0, 0, 1); next_cyc();
    drive(0, 0, 0, 0, 0);
    cnt = 0; hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (state_o == 2'd3) cnt++;
      if (done_o) hit = 1;
      next_cyc();
    end
    chk("gap_flush_len", cnt, 7);
    chk("gap_done_seen", hit, 1);

    // Abort in the second FLUSH cycle, restart immediately
    drive(1, 1, 0, 1, 1); next_cyc();
    drive(0, 0, 0, 1, 1);
    repeat (5) next_cyc();
    @(negedge clk);
    chk("abort_in_flush1", state_o, 3);
    next_cyc();
    drive(0, 0, 1, 1, 1); @(negedge clk);
    chk("abort_in_flush2", state_o, 3);
    next_cyc();
    drive(1, 1, 0, 1, 1); @(negedge clk);
    chk("abort_idle", {state_o, done_o}, {2'd0, 1'b0});
    next_cyc();
    drive(0, 0, 1, 1, 1); @(negedge clk);
    chk("restart_preload", {state_o, preload_en_o}, {2'd1, 1'b1});
    next_cyc();
    drive(0, 0, 0, 1, 1);
    hit = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done_o || state_o != 2'd0) hit = 1;
      next_cyc();
    end
    chk("abort_no_done", hit, 0);

    // Reset mid-STREAM
    drive(1, 3, 0, 1, 0); next_cyc();
    drive(0, 0, 0, 1, 1);
    repeat (5) next_cyc();
    chk("pre_reset_stream", state_o, 2);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outs", outs(), 0);
    drive(0, 0, 0, 0, 0);
    next_cyc(); next_cyc();
    rst_n = 1'b1;
    hit = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_o || busy_o) hit = 1;
      next_cyc();
    end
    chk("reset_no_done", hit, 0);

    // Maximum M
    drive(1, 8'hFF, 0, 1, 1); next_cyc();
    drive(0, 0, 0, 1, 1);
    hit = 0;
    for (int k = 1; k <= 400 && hit == 0; k++) begin
      @(negedge clk);
      if (done_o) hit = k;
      next_cyc();
    end
    chk("maxm_done_cycle", hit, 4 + 255 + 7 + 1);

    // Randomized run against the model
    rst_n = 1'b0; drive(0, 0, 0, 0, 0);
    next_cyc();
    rst_n = 1'b1;
    w_left = 0; r_left = 0; f_left = 0; done_m = 0;
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 99) < 30, 8'($urandom_range(0, 5)), $urandom_range(0, 99) < 3,
            $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 70);
      @(negedge clk);
      chk($sformatf("rand%0d", c), outs(), model_outs());
      model_step();
      next_cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sa_controller.md
SA_CONTROLLER -- requirements
Module: sa_controller

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset (clk, rst_n), per the decided interface.
REQ-002 Parameter SA_DIM, default 4, SHALL set the array dimension (weight rows to preload; flush depth).
REQ-003 Parameter MW, default 8, SHALL set the width of the streaming-length input.
REQ-004 clk  input  1  system clock, rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start_i  input  1  job start, sampled only in IDLE.
REQ-007 m_len_i  input  MW  streaming dimension M (input rows), sampled with start_i.
REQ-008 abort_i  input  1  synchronous job abort.
REQ-009 w_valid_i  input  1  weight row valid.
REQ-010 w_ready_o  output  1  controller accepts weight row.
REQ-011 in_valid_i  input  1  input row valid.
REQ-012 in_ready_o  output  1  controller accepts input row.
REQ-013 preload_en_o  output  1  array weight-shift enable.
REQ-014 shift_en_o  output  1  array data-shift enable.
REQ-015 flush_o  output  1  array inputs forced to zero.
REQ-016 state_o  output  2  current sa_state_e value.
REQ-017 busy_o  output  1  state is not IDLE.
REQ-018 done_o  output  1  one-cycle job-complete pulse.

Function
REQ-019 States SHALL be IDLE(00), PRELOAD(01), STREAM(10), FLUSH(11), held in a registered state.
REQ-020 IDLE -> PRELOAD SHALL occur when start_i=1 and m_len_i!=0; M SHALL be latched on the same edge.
REQ-021 start_i=1 with m_len_i=0 in IDLE SHALL keep IDLE and pulse done_o on the next cycle.
REQ-022 start_i outside IDLE SHALL be ignored.
REQ-023 w_ready_o SHALL be 1 exactly when state=PRELOAD; in_ready_o SHALL be 1 exactly when state=STREAM.
REQ-024 preload_en_o SHALL equal w_valid_i AND w_ready_o, combinationally.
REQ-025 Weight counter w_cnt (0..SA_DIM-1) SHALL increment on each weight handshake; handshake at w_cnt=SA_DIM-1 SHALL move to STREAM and clear w_cnt.
REQ-026 Row counter in_cnt (MW bits) SHALL increment on each input handshake; handshake at in_cnt=M-1 SHALL move to FLUSH and clear in_cnt.
REQ-027 Without a handshake, counters and state SHALL hold (stall); no timeout.
REQ-028 FLUSH SHALL last exactly 2*SA_DIM-1 cycles counted by flush_cnt; the last cycle SHALL transition to IDLE.
REQ-029 flush_o SHALL be 1 exactly when state=FLUSH.
REQ-030 shift_en_o SHALL equal (in_valid_i AND in_ready_o) OR flush_o.
REQ-031 done_o SHALL be registered, asserted for exactly the first cycle after FLUSH->IDLE.
REQ-032 abort_i=1 in any non-IDLE state SHALL force IDLE on the next edge, clear all counters, and suppress done_o; abort_i takes priority over handshakes in the same cycle.
REQ-033 M=maximum (2^MW-1) SHALL be handled without counter overflow.

Reset
REQ-034 While rst_n=0: state=IDLE, all counters 0, latched M 0, done_o=0; hence all outputs 0 (state_o=00).
REQ-035 Reset asserted mid-job SHALL abandon the job immediately with no done_o pulse after release.

Structure
REQ-036 sa_state_e SHALL live in sa_pkg with FLUSH=2'b11 enabled; SA_DIM default SHALL be a sa_pkg constant.
REQ-037 The block SHALL be one module; no sub-module is required.

Verification
REQ-038 SA_DIM=4, start with M=3, valids held high -> 4 cycles PRELOAD, 3 STREAM, 7 FLUSH, done_o at cycle 15 after start, shift_en_o high 10 cycles.
REQ-039 start with m_len_i=0 -> state stays 00, done_o pulses once next cycle, no ready asserted.
REQ-040 M=2, in_valid_i deasserted 5 cycles mid-STREAM -> in_cnt holds, shift_en_o low during gap, FLUSH still 7 cycles.
REQ-041 abort_i in cycle 2 of FLUSH -> IDLE next cycle, no done_o, new start accepted immediately after.
REQ-042 rst_n low during STREAM -> all outputs 0 asynchronously, no done_o after release.
REQ-043 start_i pulsed during PRELOAD -> ignored, latched M unchanged.
